jtopl_pg_rhy_src: RTL and testbench



---
 rtl/jtopl_pg_rhy_src_if.sv | 25 ++
 rtl/jtopl_pg_rhy_src.sv | 67 ++++++
 tb/tb_jtopl_pg_rhy_src.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtopl_pg_rhy_src_if.sv
// Bundle between the rhythm source stage and its neighbours: per-slot inputs plus
// slot/noise/ring-mod/enable outputs consumed by the rhythm phase modifier.
interface jtopl_pg_rhy_src_if;
    logic       cen;
    logic       rhy_en;
    logic [9:0] phase_pre;
    logic [4:0] slot;
    logic       zero;
    logic       noise;
    logic [9:0] hh;
    logic       rm_xor;
    logic       hh_en;
    logic       sd_en;
    logic       tc_en;

    modport master (
        output cen, rhy_en, phase_pre,
        input  slot, zero, noise, hh, rm_xor, hh_en, sd_en, tc_en
    );

    modport slave (
        input  cen, rhy_en, phase_pre,
        output slot, zero, noise, hh, rm_xor, hh_en, sd_en, tc_en
    );
endinterface

// File: rtl/jtopl_pg_rhy_src.sv
// Rhythm source stage: operator slot sequencer, 23-bit noise LFSR, HH/TC phase
// capture and the per-slot rhythm enables for the downstream phase modifier.
module jtopl_pg_rhy_src #(
    parameter int unsigned NSLOTS    = 18,
    parameter int unsigned HH_SLOT   = 13,
    parameter int unsigned SD_SLOT   = 16,
    parameter int unsigned TC_SLOT   = 17,
    parameter logic [22:0] LFSR_SEED = 23'h000001
) (
    input logic               clk,
    input logic               rst,
    jtopl_pg_rhy_src_if.slave bus
);

    localparam logic [4:0] LastSlot = 5'(NSLOTS - 1);
    localparam logic [4:0] HhSlot   = 5'(HH_SLOT);
    localparam logic [4:0] SdSlot   = 5'(SD_SLOT);
    localparam logic [4:0] TcSlot   = 5'(TC_SLOT);

    logic [4:0]  slot_q, slot_d;
    logic [22:0] lfsr_q, lfsr_d;
    logic [9:0]  hh_q, hh_d;
    logic [9:0]  tc_q, tc_d;
    logic        last_slot;

    assign last_slot = (slot_q == LastSlot);

    always_comb begin
        slot_d = slot_q;
        lfsr_d = lfsr_q;
        hh_d   = hh_q;
        tc_d   = tc_q;
        if (bus.cen) begin
            slot_d = last_slot ? 5'd0 : slot_q + 5'd1;
            // Noise steps once per sample, aligned with the slot wrap.
            if (last_slot) lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[8]};
            if (slot_q == HhSlot) hh_d = bus.phase_pre;
            if (slot_q == TcSlot) tc_d = bus.phase_pre;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= 5'd0;
            lfsr_q <= LFSR_SEED;
            hh_q   <= 10'd0;
            tc_q   <= 10'd0;
        end else begin
            slot_q <= slot_d;
            lfsr_q <= lfsr_d;
            hh_q   <= hh_d;
            tc_q   <= tc_d;
        end
    end

    // Built only from latched phases so the term never depends on phase_pre.
    assign bus.rm_xor = (hh_q[2] ^ hh_q[7]) | (hh_q[3] ^ tc_q[5]) | (tc_q[3] ^ tc_q[5]);

    assign bus.slot  = slot_q;
    assign bus.zero  = (slot_q == 5'd0);
    assign bus.noise = lfsr_q[0];
    assign bus.hh    = hh_q;
    assign bus.hh_en = bus.rhy_en & (slot_q == HhSlot);
    assign bus.sd_en = bus.rhy_en & (slot_q == SdSlot);
    assign bus.tc_en = bus.rhy_en & (slot_q == TcSlot);

endmodule

// File: tb/tb_jtopl_pg_rhy_src.sv
// Bench for jtopl_pg_rhy_src: a reference model pushes expected outputs per clock and
// each scenario task pops and compares them, plus targeted constant checks.
module tb_jtopl_pg_rhy_src;

    typedef struct packed {
        logic [4:0] slot;
        logic       zero;
        logic       noise;
        logic [9:0] hh;
        logic       rm_xor;
        logic       hh_en;
        logic       sd_en;
        logic       tc_en;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    obs_t exp_q[$];

    int          m_slot;
    logic [22:0] m_lfsr;
    logic [9:0]  m_hh;
    logic [9:0]  m_tc;

    jtopl_pg_rhy_src_if bus_if ();

    jtopl_pg_rhy_src dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        obs_t o;
        o.slot   = bus_if.slot;
        o.zero   = bus_if.zero;
        o.noise  = bus_if.noise;
        o.hh     = bus_if.hh;
        o.rm_xor = bus_if.rm_xor;
        o.hh_en  = bus_if.hh_en;
        o.sd_en  = bus_if.sd_en;
        o.tc_en  = bus_if.tc_en;
        return o;
    endfunction

    function automatic obs_t model_now();
        obs_t o;
        o.slot   = 5'(m_slot);
        o.zero   = (m_slot == 0);
        o.noise  = m_lfsr[0];
        o.hh     = m_hh;
        o.rm_xor = (m_hh[2] ^ m_hh[7]) | (m_hh[3] ^ m_tc[5]) | (m_tc[3] ^ m_tc[5]);
        o.hh_en  = bus_if.rhy_en && (m_slot == 13);
        o.sd_en  = bus_if.rhy_en && (m_slot == 16);
        o.tc_en  = bus_if.rhy_en && (m_slot == 17);
        return o;
    endfunction

    // Drive one clock of stimulus, advance the model and queue the expected outputs.
    task automatic cycle(input logic r, input logic c, input logic rh, input logic [9:0] ph);
        rst              = r;
        bus_if.cen       = c;
        bus_if.rhy_en    = rh;
        bus_if.phase_pre = ph;
        @(posedge clk);
        if (r) begin
            m_slot = 0;
            m_lfsr = 23'h000001;
            m_hh   = '0;
            m_tc   = '0;
        end else if (c) begin
            if (m_slot == 13) m_hh = ph;
            if (m_slot == 17) m_tc = ph;
            if (m_slot == 17) begin
                m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[8]};
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
        #1;
        exp_q.push_back(model_now());
    endtask

    task automatic test_reset();
        obs_t e, a;
        cycle(1'b1, 1'b0, 1'b0, 10'h3ff);
        a = observe();
        e = exp_q.pop_front();
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL reset_sb: got %h required %h", a, e);
        end
        n_checks++;
        if ({a.slot, a.zero, a.noise, a.hh, a.rm_xor} !== {5'd0, 1'b1, 1'b1, 10'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_const: got slot=%0d zero=%b noise=%b hh=%h rm=%b required 0 1 1 000 0",
                     a.slot, a.zero, a.noise, a.hh, a.rm_xor);
        end
    endtask

    task automatic test_slot_run();
        obs_t e, a;
        for (int i = 1; i < 40; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 10'(i));
            a = observe();
            e = exp_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL slot_run_sb[%0d]: got %h required %h", i, a, e);
            end
            n_checks++;
            if (a.slot !== 5'(i % 18) || a.zero !== (i % 18 == 0)) begin
                n_errors++;
                $display("FAIL slot_run[%0d]: got slot=%0d zero=%b required slot=%0d zero=%b",
                         i, a.slot, a.zero, i % 18, i % 18 == 0);
            end
        end
        // slot is 3 now; run to 9 then reset
        while (m_slot != 9) begin
            cycle(1'b0, 1'b1, 1'b0, 10'h0);
            void'(exp_q.pop_front());
        end
        cycle(1'b1, 1'b1, 1'b0, 10'h0);
        a = observe();
        e = exp_q.pop_front();
        n_checks++;
        if (a !== e || a.slot !== 5'd0) begin
            n_errors++;
            $display("FAIL mid_reset_slot: got %h required %h (slot 0)", a, e);
        end
    endtask

    task automatic test_cen();
        obs_t e, a;
        cycle(1'b1, 1'b0, 1'b0, 10'h0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 36; i++) begin
            cycle(1'b0, (i % 2 == 0), 1'b0, 10'($urandom_range(0, 1023)));
            a = observe();
            e = exp_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cen_sb[%0d]: got %h required %h", i, a, e);
            end
        end
        a = observe();
        n_checks++;
        if (a.slot !== 5'd0 || a.noise !== 1'b0) begin
            n_errors++;
            $display("FAIL cen_sample_len: got slot=%0d noise=%b required slot=0 noise=0",
                     a.slot, a.noise);
        end
    endtask

    task automatic test_lfsr();
        obs_t e, a;
        cycle(1'b1, 1'b0, 1'b0, 10'h0);
        void'(exp_q.pop_front());
        for (int s = 1; s <= 9; s++) begin
            for (int k = 0; k < 18; k++) begin
                cycle(1'b0, 1'b1, 1'b0, 10'h0);
                a = observe();
                e = exp_q.pop_front();
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL lfsr_sb[%0d.%0d]: got %h required %h", s, k, a, e);
                end
            end
            n_checks++;
            if (bus_if.noise !== (s == 9)) begin
                n_errors++;
                $display("FAIL lfsr_noise[%0d]: got %b required %b", s, bus_if.noise, s == 9);
            end
        end
        n_checks++;
        if (dut.lfsr_q !== 23'h000201) begin
            n_errors++;
            $display("FAIL lfsr_state: got %h required 000201", dut.lfsr_q);
        end
    endtask

    task automatic test_rm_xor();
        obs_t e, a;
        logic [9:0] ph;
        cycle(1'b1, 1'b0, 1'b0, 10'h0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 54; i++) begin
            ph = 10'($urandom_range(0, 1023));
            if (m_slot == 13) ph = (i < 18) ? 10'h084 : (i < 36 ? 10'h004 : 10'h084);
            if (m_slot == 17) ph = (i < 18) ? 10'h000 : (i < 36 ? 10'h008 : 10'h000);
            cycle(1'b0, 1'b1, 1'b0, ph);
            a = observe();
            e = exp_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL rm_xor_sb[%0d]: got %h required %h", i, a, e);
            end
            if (i == 17 || i == 18 + 14 || i == 36 + 14 || i == 18 + 18) begin
                n_checks++;
                if (i == 17 && (a.hh !== 10'h084 || a.rm_xor !== 1'b0)) begin
                    n_errors++;
                    $display("FAIL rm_xor_first: got hh=%h rm=%b required 084 0", a.hh, a.rm_xor);
                end
                if ((i == 32 || i == 36) && a.rm_xor !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rm_xor_set[%0d]: got %b required 1", i, a.rm_xor);
                end
                // hh back to 084 with tc=008: tc[3]^tc[5] alone keeps the term high
                if (i == 50 && (a.hh !== 10'h084 || a.rm_xor !== 1'b1)) begin
                    n_errors++;
                    $display("FAIL rm_xor_tc: got hh=%h rm=%b required 084 1", a.hh, a.rm_xor);
                end
            end
        end
    endtask

    task automatic test_enables();
        obs_t e, a;
        cycle(1'b1, 1'b0, 1'b1, 10'h0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 36; i++) begin
            cycle(1'b0, 1'b1, (i < 18), 10'($urandom_range(0, 1023)));
            a = observe();
            e = exp_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL enables_sb[%0d]: got %h required %h", i, a, e);
            end
            n_checks++;
            if ({a.hh_en, a.sd_en, a.tc_en} !==
                {(i < 18) && (i + 1) % 18 == 13, (i < 18) && (i + 1) % 18 == 16,
                 (i < 18) && (i + 1) % 18 == 17}) begin
                n_errors++;
                $display("FAIL enables[%0d]: got hh/sd/tc=%b%b%b at slot %0d rhy_en=%b",
                         i, a.hh_en, a.sd_en, a.tc_en, a.slot, i < 18);
            end
        end
    endtask

    task automatic test_reset_mid_rhy();
        obs_t e, a;
        while (m_slot != 16) begin
            cycle(1'b0, 1'b1, 1'b1, 10'h004);
            void'(exp_q.pop_front());
        end
        a = observe();
        n_checks++;
        if (a.sd_en !== 1'b1 || a.hh !== 10'h004 || a.rm_xor !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset: got sd_en=%b hh=%h rm=%b required 1 004 1",
                     a.sd_en, a.hh, a.rm_xor);
        end
        cycle(1'b1, 1'b1, 1'b1, 10'h004);
        a = observe();
        e = exp_q.pop_front();
        n_checks++;
        if (a !== e || a.sd_en !== 1'b0 || a.hh !== 10'h0 || a.rm_xor !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_rhy: got %h required %h (sd_en=0 hh=0 rm=0)", a, e);
        end
    endtask

    initial begin
        bus_if.cen       = 1'b0;
        bus_if.rhy_en    = 1'b0;
        bus_if.phase_pre = '0;
        m_slot = 0;
        m_lfsr = 23'h000001;
        m_hh   = '0;
        m_tc   = '0;
        #1;
        test_reset();
        test_slot_run();
        test_cen();
        test_lfsr();
        test_rm_xor();
        test_enables();
        test_reset_mid_rhy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
